mem_bus_arbiter: RTL and testbench

//  Shares the single 64-bit AHB-lite master port between instruction fetch (IF) and the
//  mem_access stage (MEM). Selects one requester per transfer, sequences the AHB address
//  and data phases, absorbs HREADY wait states, and returns read data, completion and

---
 rtl/mem_bus_arbiter.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// ----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares one 64-bit AHB-lite master port between instruction fetch (IF) and
// the mem_access stage (MEM). One transfer is outstanding at a time: a grant
// in IDLE launches a NONSEQ address phase, followed by a data phase, followed
// by a single-cycle rvalid pulse to the owner. HREADY wait states stretch
// either phase. A phase that stays stalled for MAX_WAIT counted cycles is
// aborted and reported as an error.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined   : on simultaneous requests the requester that did not own the
//               previous grant wins (last_owner register present)
//   undefined : fixed priority, MEM beats IF
//
// Ports
//   CLK, RST                      clock (rising edge), async active-high reset
//   if_req/if_addr                IF read request and address
//   if_gnt                        IF request accepted (combinational, IDLE only)
//   if_rvalid/if_rdata/if_err     IF completion pulse, read data, error flag
//   mem_req/mem_write/mem_addr/mem_wdata   MEM request, direction, addr, data
//   mem_gnt                       MEM request accepted (combinational, IDLE only)
//   mem_rvalid/mem_rdata/mem_err  MEM completion pulse, read data, error flag
//   HADDR/HWDATA/HWRITE/HTRANS    AHB-lite master outputs
//   HRDATA/HREADY/HRESP           AHB-lite master inputs
// ----------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 64,
    parameter int MAX_WAIT = 255
) (
    input  logic              CLK,
    input  logic              RST,
    // instruction fetch
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    // mem_access stage
    input  logic              mem_req,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_gnt,
    output logic              mem_rvalid,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_err,
    // AHB-lite master
    output logic [ADDR_W-1:0] HADDR,
    output logic [DATA_W-1:0] HWDATA,
    output logic              HWRITE,
    output logic [1:0]        HTRANS,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HREADY,
    input  logic              HRESP
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [7:0] MAX_WAIT_C    = 8'(MAX_WAIT);

    state_t              state_q,      state_d;
    owner_t              owner_q,      owner_d;
    logic [7:0]          wait_cnt_q,   wait_cnt_d;
    logic [ADDR_W-1:0]   haddr_q,      haddr_d;
    logic [DATA_W-1:0]   hwdata_q,     hwdata_d;
    logic [DATA_W-1:0]   wdata_q,      wdata_d;
    logic                hwrite_q,     hwrite_d;
    logic [1:0]          htrans_q,     htrans_d;
    logic                if_rvalid_q,  if_rvalid_d;
    logic [DATA_W-1:0]   if_rdata_q,   if_rdata_d;
    logic                if_err_q,     if_err_d;
    logic                mem_rvalid_q, mem_rvalid_d;
    logic [DATA_W-1:0]   mem_rdata_q,  mem_rdata_d;
    logic                mem_err_q,    mem_err_d;

    logic                mem_pick;
    logic                if_pick;
    logic                fin;
    logic                fin_err;
    logic                fin_rd;

    // ------------------------------------------------------------------
    // Arbitration: decide who would win if the FSM is idle
    // ------------------------------------------------------------------
`ifdef ARB_ROUND_ROBIN_EN
    owner_t last_owner_q, last_owner_d;

    // On a tie the requester that did not own the previous grant wins.
    assign mem_pick = mem_req && (!if_req || (last_owner_q == OWN_IF));

    always_comb begin
        last_owner_d = last_owner_q;
        if (mem_gnt) begin
            last_owner_d = OWN_MEM;
        end else if (if_gnt) begin
            last_owner_d = OWN_IF;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_owner_q <= OWN_IF;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end
`else
    assign mem_pick = mem_req;
`endif

    assign if_pick = if_req && !mem_pick;

    assign mem_gnt = (state_q == ST_IDLE) && mem_pick;
    assign if_gnt  = (state_q == ST_IDLE) && if_pick;

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        wait_cnt_d   = wait_cnt_q;
        haddr_d      = haddr_q;
        hwdata_d     = hwdata_q;
        wdata_d      = wdata_q;
        hwrite_d     = hwrite_q;
        htrans_d     = htrans_q;
        if_rvalid_d  = 1'b0;
        if_rdata_d   = if_rdata_q;
        if_err_d     = if_err_q;
        mem_rvalid_d = 1'b0;
        mem_rdata_d  = mem_rdata_q;
        mem_err_d    = mem_err_q;
        fin          = 1'b0;
        fin_err      = 1'b0;
        fin_rd       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                htrans_d = HTRANS_IDLE;
                if (mem_gnt) begin
                    haddr_d    = mem_addr;
                    hwrite_d   = mem_write;
                    wdata_d    = mem_wdata;
                    owner_d    = OWN_MEM;
                    htrans_d   = HTRANS_NONSEQ;
                    wait_cnt_d = 8'd0;
                    state_d    = ST_ADDR;
                end else if (if_gnt) begin
                    haddr_d    = if_addr;
                    hwrite_d   = 1'b0;
                    owner_d    = OWN_IF;
                    htrans_d   = HTRANS_NONSEQ;
                    wait_cnt_d = 8'd0;
                    state_d    = ST_ADDR;
                end
            end

            ST_ADDR: begin
                if (HREADY) begin
                    // Address accepted: write data is driven for the whole data phase.
                    htrans_d   = HTRANS_IDLE;
                    if (hwrite_q) begin
                        hwdata_d = wdata_q;
                    end
                    wait_cnt_d = 8'd0;
                    state_d    = ST_DATA;
                end else if (wait_cnt_q == MAX_WAIT_C) begin
                    fin        = 1'b1;
                    fin_err    = 1'b1;
                    htrans_d   = HTRANS_IDLE;
                    wait_cnt_d = 8'd0;
                    state_d    = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end

            ST_DATA: begin
                if (HREADY) begin
                    fin        = 1'b1;
                    fin_err    = HRESP;
                    fin_rd     = !hwrite_q;
                    wait_cnt_d = 8'd0;
                    state_d    = ST_IDLE;
                end else if (wait_cnt_q == MAX_WAIT_C) begin
                    fin        = 1'b1;
                    fin_err    = 1'b1;
                    htrans_d   = HTRANS_IDLE;
                    wait_cnt_d = 8'd0;
                    state_d    = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end

            default: begin
                htrans_d   = HTRANS_IDLE;
                wait_cnt_d = 8'd0;
                state_d    = ST_IDLE;
            end
        endcase

        // Completion is routed to whoever owns the transfer. Read data is
        // only replaced by a successful-phase read; aborts and writes keep it.
        if (fin) begin
            if (owner_q == OWN_MEM) begin
                mem_rvalid_d = 1'b1;
                mem_err_d    = fin_err;
                if (fin_rd) begin
                    mem_rdata_d = HRDATA;
                end
            end else begin
                if_rvalid_d = 1'b1;
                if_err_d    = fin_err;
                if (fin_rd) begin
                    if_rdata_d = HRDATA;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_IF;
            wait_cnt_q   <= 8'd0;
            haddr_q      <= '0;
            hwdata_q     <= '0;
            wdata_q      <= '0;
            hwrite_q     <= 1'b0;
            htrans_q     <= HTRANS_IDLE;
            if_rvalid_q  <= 1'b0;
            if_rdata_q   <= '0;
            if_err_q     <= 1'b0;
            mem_rvalid_q <= 1'b0;
            mem_rdata_q  <= '0;
            mem_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            wait_cnt_q   <= wait_cnt_d;
            haddr_q      <= haddr_d;
            hwdata_q     <= hwdata_d;
            wdata_q      <= wdata_d;
            hwrite_q     <= hwrite_d;
            htrans_q     <= htrans_d;
            if_rvalid_q  <= if_rvalid_d;
            if_rdata_q   <= if_rdata_d;
            if_err_q     <= if_err_d;
            mem_rvalid_q <= mem_rvalid_d;
            mem_rdata_q  <= mem_rdata_d;
            mem_err_q    <= mem_err_d;
        end
    end

    assign HADDR      = haddr_q;
    assign HWDATA     = hwdata_q;
    assign HWRITE     = hwrite_q;
    assign HTRANS     = htrans_q;
    assign if_rvalid  = if_rvalid_q;
    assign if_rdata   = if_rdata_q;
    assign if_err     = if_err_q;
    assign mem_rvalid = mem_rvalid_q;
    assign mem_rdata  = mem_rdata_q;
    assign mem_err    = mem_err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Directed bench for mem_bus_arbiter. The AHB slave side is driven cycle by
// cycle from the main sequence. Every granted transfer pushes its expected
// completion (owner, read data, error) onto a queue; a monitor pops and
// compares on each rvalid pulse. Phase timing and bus outputs are checked
// directly by the main sequence.
// ----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    localparam int ADDR_W   = 64;
    localparam int DATA_W   = 64;
    localparam int MAX_WAIT = 255;

    logic              CLK = 1'b0;
    logic              RST;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              if_err;
    logic              mem_req;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_err;
    logic [ADDR_W-1:0] HADDR;
    logic [DATA_W-1:0] HWDATA;
    logic              HWRITE;
    logic [1:0]        HTRANS;
    logic [DATA_W-1:0] HRDATA;
    logic              HREADY;
    logic              HRESP;

    mem_bus_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .if_err     (if_err),
        .mem_req    (mem_req),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .mem_err    (mem_err),
        .HADDR      (HADDR),
        .HWDATA     (HWDATA),
        .HWRITE     (HWRITE),
        .HTRANS     (HTRANS),
        .HRDATA     (HRDATA),
        .HREADY     (HREADY),
        .HRESP      (HRESP)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic              is_mem;
        logic [DATA_W-1:0] rdata;
        logic              err;
    } exp_t;

    exp_t sb[$];

    int n_vec  = 0;
    int n_miss = 0;

    logic [DATA_W-1:0] exp_if_rdata  = '0;
    logic [DATA_W-1:0] exp_mem_rdata = '0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic push_exp(input logic is_mem, input logic [DATA_W-1:0] rd, input logic err);
        exp_t e;
        e.is_mem = is_mem;
        e.rdata  = rd;
        e.err    = err;
        sb.push_back(e);
    endtask

    // Scoreboard monitor and mutual-exclusion checks
    always @(negedge CLK) begin
        exp_t e;
        check_val("gnt_excl", 64'(if_gnt & mem_gnt), 64'd0);
        check_val("rvalid_excl", 64'(if_rvalid & mem_rvalid), 64'd0);
        if (if_rvalid || mem_rvalid) begin
            if (sb.size() == 0) begin
                check_val("unexpected_rvalid", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check_val("rv_owner_mem", 64'(mem_rvalid), 64'(e.is_mem));
                if (e.is_mem) begin
                    check_val("mem_rdata", mem_rdata, e.rdata);
                    check_val("mem_err", 64'(mem_err), 64'(e.err));
                end else begin
                    check_val("if_rdata", if_rdata, e.rdata);
                    check_val("if_err", 64'(if_err), 64'(e.err));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic first_mem;
        logic [63:0] d1, d2;
        int n;

        RST       = 1'b1;
        if_req    = 1'b0;
        if_addr   = '0;
        mem_req   = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        HRDATA    = '0;
        HREADY    = 1'b1;
        HRESP     = 1'b0;

        // ---- reset state
        repeat (2) tick();
        check_val("rst_htrans", 64'(HTRANS), 64'd0);
        check_val("rst_haddr", HADDR, 64'd0);
        check_val("rst_hwrite", 64'(HWRITE), 64'd0);
        check_val("rst_hwdata", HWDATA, 64'd0);
        check_val("rst_rvalid", 64'({if_rvalid, mem_rvalid}), 64'd0);
        check_val("rst_rdata", if_rdata | mem_rdata, 64'd0);
        check_val("rst_err", 64'({if_err, mem_err}), 64'd0);
        RST = 1'b0;
        tick();

        // ---- IF read, zero wait states
        HRDATA  = 64'h13;
        if_req  = 1'b1;
        if_addr = 64'h1000;
        #1;
        check_val("t1_if_gnt_c0", 64'(if_gnt), 64'd1);
        check_val("t1_mem_gnt_c0", 64'(mem_gnt), 64'd0);
        push_exp(1'b0, 64'h13, 1'b0);
        exp_if_rdata = 64'h13;
        tick();
        if_req = 1'b0;
        check_val("t1_htrans_c1", 64'(HTRANS), 64'd2);
        check_val("t1_haddr_c1", HADDR, 64'h1000);
        check_val("t1_hwrite_c1", 64'(HWRITE), 64'd0);
        tick();
        check_val("t1_htrans_c2", 64'(HTRANS), 64'd0);
        check_val("t1_rvalid_c2", 64'(if_rvalid), 64'd0);
        tick();
        check_val("t1_rvalid_c3", 64'(if_rvalid), 64'd1);
        tick();
        check_val("t1_rvalid_pulse", 64'(if_rvalid), 64'd0);

        // ---- MEM write with two data-phase wait states
        mem_req   = 1'b1;
        mem_write = 1'b1;
        mem_addr  = 64'h8000_0000;
        mem_wdata = 64'hDEAD_BEEF;
        #1;
        check_val("t2_mem_gnt_c0", 64'(mem_gnt), 64'd1);
        push_exp(1'b1, exp_mem_rdata, 1'b0);
        tick();
        mem_req   = 1'b0;
        mem_write = 1'b0;
        mem_wdata = '0;
        check_val("t2_htrans_c1", 64'(HTRANS), 64'd2);
        check_val("t2_hwrite_c1", 64'(HWRITE), 64'd1);
        check_val("t2_haddr_c1", HADDR, 64'h8000_0000);
        tick();
        check_val("t2_hwdata_c2", HWDATA, 64'hDEAD_BEEF);
        check_val("t2_htrans_c2", 64'(HTRANS), 64'd0);
        HREADY = 1'b0;
        tick();
        check_val("t2_hwdata_c3", HWDATA, 64'hDEAD_BEEF);
        check_val("t2_rvalid_c3", 64'(mem_rvalid), 64'd0);
        tick();
        HREADY = 1'b1;
        check_val("t2_rvalid_c4", 64'(mem_rvalid), 64'd0);
        tick();
        check_val("t2_rvalid_c5", 64'(mem_rvalid), 64'd1);
        tick();

        // ---- simultaneous requests (last owner is MEM at this point)
`ifdef ARB_ROUND_ROBIN_EN
        first_mem = 1'b0;
`else
        first_mem = 1'b1;
`endif
        d1 = 64'h1111_2222_3333_4444;
        d2 = 64'h5555_6666_7777_8888;
        HRDATA    = d1;
        mem_req   = 1'b1;
        mem_write = 1'b0;
        mem_addr  = 64'h2000;
        if_req    = 1'b1;
        if_addr   = 64'h3000;
        #1;
        check_val("t3_mem_gnt_c0", 64'(mem_gnt), 64'(first_mem));
        check_val("t3_if_gnt_c0", 64'(if_gnt), 64'(!first_mem));
        push_exp(first_mem, d1, 1'b0);
        if (first_mem) exp_mem_rdata = d1;
        else           exp_if_rdata  = d1;
        tick();
        if (first_mem) mem_req = 1'b0;
        else           if_req  = 1'b0;
        check_val("t3_haddr_first", HADDR, first_mem ? 64'h2000 : 64'h3000);
        check_val("t3_no_gnt_busy", 64'(if_gnt | mem_gnt), 64'd0);
        tick();
        tick();
        check_val("t3_second_gnt_c3", 64'(first_mem ? if_gnt : mem_gnt), 64'd1);
        HRDATA = d2;
        push_exp(!first_mem, d2, 1'b0);
        if (first_mem) exp_if_rdata  = d2;
        else           exp_mem_rdata = d2;
        tick();
        if_req  = 1'b0;
        mem_req = 1'b0;
        check_val("t3_haddr_second", HADDR, first_mem ? 64'h3000 : 64'h2000);
        tick();
        tick();
        check_val("t3_second_rvalid_c6", 64'(first_mem ? if_rvalid : mem_rvalid), 64'd1);
        tick();

        // ---- MEM read with ERROR response, then an IF read
        HRDATA   = 64'h55;
        HRESP    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = 64'h4000;
        #1;
        check_val("t4_mem_gnt", 64'(mem_gnt), 64'd1);
        push_exp(1'b1, 64'h55, 1'b1);
        exp_mem_rdata = 64'h55;
        tick();
        mem_req = 1'b0;
        tick();
        tick();
        check_val("t4_err_rvalid", 64'({mem_rvalid, mem_err}), 64'h3);
        HRESP   = 1'b0;
        HRDATA  = 64'h77;
        if_req  = 1'b1;
        if_addr = 64'h5000;
        #1;
        check_val("t4_next_if_gnt", 64'(if_gnt), 64'd1);
        push_exp(1'b0, 64'h77, 1'b0);
        exp_if_rdata = 64'h77;
        tick();
        if_req = 1'b0;
        tick();
        tick();
        check_val("t4_if_rvalid", 64'(if_rvalid), 64'd1);
        check_val("t4_mem_rdata_held", mem_rdata, 64'h55);
        tick();

        // ---- address-phase timeout
        HREADY  = 1'b0;
        if_req  = 1'b1;
        if_addr = 64'h6000;
        #1;
        check_val("t5_if_gnt", 64'(if_gnt), 64'd1);
        push_exp(1'b0, exp_if_rdata, 1'b1);
        tick();
        if_req = 1'b0;
        n = 1;
        while (!if_rvalid && n < 400) begin
            if (n == 100) check_val("t5_htrans_held", 64'(HTRANS), 64'd2);
            tick();
            n++;
        end
        check_val("t5_timeout_cycle", 64'(n), 64'(MAX_WAIT + 2));
        check_val("t5_rvalid", 64'(if_rvalid), 64'd1);
        check_val("t5_htrans_idle", 64'(HTRANS), 64'd0);
        HREADY = 1'b1;
        tick();

        // ---- reset during the data phase of an IF read
        HRDATA  = 64'h99;
        if_req  = 1'b1;
        if_addr = 64'h7000;
        #1;
        check_val("t6_if_gnt", 64'(if_gnt), 64'd1);
        tick();
        if_req = 1'b0;
        tick();
        HREADY = 1'b0;
        tick();
        RST = 1'b1;
        #1;
        check_val("t6_rst_htrans", 64'(HTRANS), 64'd0);
        check_val("t6_rst_haddr", HADDR, 64'd0);
        check_val("t6_rst_if_out", 64'({if_rvalid, if_err}), 64'd0);
        check_val("t6_rst_if_rdata", if_rdata, 64'd0);
        exp_if_rdata  = '0;
        exp_mem_rdata = '0;
        tick();
        RST    = 1'b0;
        HREADY = 1'b1;
        repeat (3) tick();
        HRDATA  = 64'hAB;
        if_req  = 1'b1;
        if_addr = 64'h8;
        #1;
        check_val("t6_post_rst_gnt", 64'(if_gnt), 64'd1);
        push_exp(1'b0, 64'hAB, 1'b0);
        tick();
        if_req = 1'b0;
        tick();
        tick();
        check_val("t6_post_rst_rvalid", 64'(if_rvalid), 64'd1);
        tick();
        tick();

        check_val("sb_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
